// File: rtl/sd_dac_pkg.sv
// Shared types and constants for the delta-sigma transmitter and its density-count receiver.
package sd_dac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_WIN_LOG2 = 8;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_dac_fifo.sv
// Small synchronous sample buffer feeding the modulator; show-ahead read data.
module sd_dac_fifo
  import sd_dac_pkg::*;
#(
  parameter int W     = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/sd_dac_tx.sv
// First-order delta-sigma transmitter: one buffered sample per 2^WIN_LOG2-clock window.
// Define SD_DAC_DITHER_EN to add a +0/+1 LFSR dither term to the accumulator.
module sd_dac_tx
  import sd_dac_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int WIN_LOG2   = DEF_WIN_LOG2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             clr_underrun,
  output logic             bit_out,
  output logic             active,
  output logic             underrun,
  output logic             win_start
);

  localparam int SHIFT = WIN_LOG2 - WIDTH;
  localparam int SW    = WIN_LOG2 + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q, state_d;
  logic [WIN_LOG2-1:0] acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic                bit_q, bit_d;
  logic                win_start_q, win_start_d;
  logic                underrun_q, underrun_d;
  logic                underrun_set;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0]    fifo_rd;
  logic [CW-1:0]       fifo_cnt;

  logic [WIN_LOG2-1:0] addend;
  logic [SW-1:0]       sum;
  logic                dith;
  logic                win_end;

  sd_dac_fifo #(
    .W     (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fifo_push),
    .wr_data_i (s_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;

`ifdef SD_DAC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == RUN) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign dith = lfsr_q[0];
`else
  assign dith = 1'b0;
`endif

  assign addend  = WIN_LOG2'(cur_q) << SHIFT;
  assign sum     = SW'(acc_q) + SW'(addend) + SW'(dith);
  assign win_end = (win_cnt_q == '1);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    win_cnt_d    = win_cnt_q;
    cur_d        = cur_q;
    bit_d        = 1'b0;
    win_start_d  = 1'b0;
    fifo_pop     = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (en && !fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_d     = fifo_rd;
          win_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d       = sum[WIN_LOG2-1:0];
        bit_d       = sum[WIN_LOG2];
        win_cnt_d   = win_cnt_q + WIN_LOG2'(1);
        win_start_d = (win_cnt_q == '0);
        // acc is kept across back-to-back windows so residual error carries over
        if (win_end) begin
          if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
          end else if (fifo_cnt != '0) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_rd;
          end else begin
            underrun_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    underrun_d = underrun_set | (underrun_q & ~clr_underrun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      win_cnt_q   <= '0;
      cur_q       <= '0;
      bit_q       <= 1'b0;
      win_start_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      cur_q       <= cur_d;
      bit_q       <= bit_d;
      win_start_q <= win_start_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bit_out   = bit_q;
  assign active    = (state_q == RUN);
  assign underrun  = underrun_q;
  assign win_start = win_start_q;

endmodule

// File: tb/tb_sd_dac_tx.sv
// Directed + randomized bench for sd_dac_tx; expected bitstreams come from a closed-form density model.
module tb_sd_dac_tx;

  localparam int WIDTH    = 8;
  localparam int WIN_LOG2 = 8;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int SHIFT    = WIN_LOG2 - WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             clr_underrun = 1'b0;
  logic             bit_out, active, underrun, win_start;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] seq[$];

  always #5 clk = ~clk;

  sd_dac_tx #(
    .WIDTH      (WIDTH),
    .WIN_LOG2   (WIN_LOG2),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .clr_underrun (clr_underrun),
    .bit_out      (bit_out),
    .active       (active),
    .underrun     (underrun),
    .win_start    (win_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal first-order density: bit k of a window started from an empty accumulator
  function automatic int ref_bit(input int v, input int k);
    int vs;
    vs = v << SHIFT;
    return ((k + 1) * vs) / WIN - (k * vs) / WIN;
  endfunction

  task automatic push(input logic [WIDTH-1:0] v);
    s_data  = v;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic collect_window(input string tag, input int v, input bit do_push,
                                input logic [WIDTH-1:0] push_v, input bit clr_first,
                                input bit clr_last, input int en_off_at);
    int ones;
    int bad;
    int r;
    ones = 0;
    bad  = 0;
    for (int i = 0; i < WIN; i++) begin
      if (i == 0 && do_push) begin
        s_data  = push_v;
        s_valid = 1'b1;
      end
      if ((i == 0 && clr_first) || (i == WIN - 1 && clr_last)) clr_underrun = 1'b1;
      step();
      s_valid      = 1'b0;
      clr_underrun = 1'b0;
      r = ref_bit(v, i);
      if (bit_out === 1'b1) ones++;
      if (bit_out !== r[0]) bad++;
      if (win_start !== (i == 0)) bad++;
      if (i == 0) check({tag, " win_start"}, win_start, 1);
      if (i == 0 && clr_first) check({tag, " clr"}, underrun, 0);
      if (i == WIN - 1 && clr_last) check({tag, " set_wins"}, underrun, 1);
      if (i == en_off_at) en = 1'b0;
    end
    check({tag, " ones"}, ones, v << SHIFT);
    check({tag, " pattern"}, bad, 0);
  endtask

  task automatic run_stream(input string tag);
    int n;
    n = seq.size();
    push(seq[0]);
    push(seq[1]);
    check({tag, " s_ready_full"}, s_ready, 0);
    en = 1'b1;
    step();
    check({tag, " s_ready_pop"}, s_ready, 1);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) en = 1'b0;
      collect_window($sformatf("%s w%0d", tag, k), int'(seq[k]), (k + 2 < n),
                     (k + 2 < n) ? seq[k+2] : '0, 1'b0, 1'b0, -1);
    end
    check({tag, " end_active"}, active, 0);
    check({tag, " no_underrun"}, underrun, 0);
    step();
    check({tag, " end_bit"}, bit_out, 0);
  endtask

  initial begin
    int bad;
    int off;

    // reset state
    repeat (3) step();
    check("rst bit_out", bit_out, 0);
    check("rst active", active, 0);
    check("rst underrun", underrun, 0);
    check("rst win_start", win_start, 0);
    check("rst s_ready", s_ready, 1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bit_out !== 1'b0 || active !== 1'b0 || s_ready !== 1'b1) bad++;
    end
    check("idle quiet", bad, 0);

    // single sample 64, then starve
    en = 1'b1;
    push(8'd64);
    check("t2 pre_active", active, 0);
    step();
    check("t2 pop_active", active, 1);
    check("t2 pop_bit", bit_out, 0);
    check("t2 pop_win_start", win_start, 0);
    collect_window("t2", 64, 1'b0, '0, 1'b0, 1'b0, -1);
    check("t2 underrun", underrun, 1);
    en = 1'b0;
    collect_window("t2 rpt", 64, 1'b0, '0, 1'b0, 1'b0, -1);
    check("t2 stop_active", active, 0);
    step();
    check("t2 stop_bit", bit_out, 0);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    check("t2 clr", underrun, 0);

    // back-to-back directed, then random
    seq = '{8'd0, 8'd255, 8'd128};
    run_stream("t3");
    seq.delete();
    for (int i = 0; i < 5; i++) seq.push_back(WIDTH'($urandom_range(0, 255)));
    run_stream("rnd");

    // starvation with 200, set/clear collision
    en = 1'b1;
    push(8'd200);
    step();
    collect_window("t4 w0", 200, 1'b0, '0, 1'b0, 1'b0, -1);
    check("t4 underrun", underrun, 1);
    collect_window("t4 w1", 200, 1'b0, '0, 1'b1, 1'b1, -1);
    collect_window("t4 w2", 200, 1'b0, '0, 1'b0, 1'b0, 0);
    check("t4 stop_active", active, 0);
    check("t4 sticky", underrun, 1);

    // en dropped mid-window with a queued sample
    push(8'd77);
    step();
    check("t5 hold_idle", active, 0);
    en = 1'b1;
    step();
    check("t5 run", active, 1);
    collect_window("t5", 77, 1'b1, 8'd99, 1'b0, 1'b0, 9);
    check("t5 stop_active", active, 0);
    step();
    check("t5 stop_bit", bit_out, 0);
    check("t5 s_ready", s_ready, 1);
    repeat (20) step();
    check("t5 queued_idle", active, 0);
    off = $urandom_range(1, 200);
    en = 1'b1;
    step();
    check("t5 queued_run", active, 1);
    collect_window("t5 q", 99, 1'b0, '0, 1'b0, 1'b0, off);
    check("t5 q_stop", active, 0);

    // reset mid-window
    en = 1'b1;
    push(8'd255);
    step();
    s_data  = 8'd60;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (30) step();
    check("t6 pre_active", active, 1);
    rst = 1'b1;
    step();
    check("t6 bit_out", bit_out, 0);
    check("t6 active", active, 0);
    check("t6 underrun", underrun, 0);
    check("t6 win_start", win_start, 0);
    check("t6 s_ready", s_ready, 1);
    rst = 1'b0;
    repeat (5) step();
    check("t6 fifo_flushed", active, 0);
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
